// File: rtl/q_gate_pipe_pkg.sv
// rtl/q_gate_pipe_pkg.sv - shared types and elaboration helpers for the pipelined gate unit
package q_gate_pkg;

    // Gate select encoding as carried on in_op
    typedef enum logic [2:0] {
        OP_I    = 3'd0,
        OP_X    = 3'd1,
        OP_Z    = 3'd2,
        OP_H    = 3'd3,
        OP_S    = 3'd4,
        OP_T    = 3'd5,
        OP_Y    = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    // Default-geometry beat record (16-bit amplitudes, 8-bit tag)
    localparam int BEAT_W     = 16;
    localparam int BEAT_TAG_W = 8;

    typedef struct packed {
        logic signed [BEAT_W-1:0]     a_re;
        logic signed [BEAT_W-1:0]     a_im;
        logic signed [BEAT_W-1:0]     b_re;
        logic signed [BEAT_W-1:0]     b_im;
        logic        [BEAT_TAG_W-1:0] tag;
        op_e                          op;
    } beat_t;

    // round(2^frac / sqrt(2)) == round(sqrt(2^(2*frac-1))), done with an integer square root
    function automatic int inv_sqrt2_const(input int frac);
        longint n;
        longint r;
        longint cand;
        n = longint'(1) << (2 * frac - 1);
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            cand = r | (longint'(1) << i);
            if (cand * cand <= n) begin
                r = cand;
            end
        end
        // round to nearest: bump when (r + 0.5)^2 <= n
        if (4 * r * r + 4 * r + 1 <= 4 * n) begin
            r = r + longint'(1);
        end
        return int'(r);
    endfunction

    // Value produced when the most negative amplitude is negated (clamped positive bound)
    function automatic int sat_neg(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/q_gate_pipe_if.sv
// rtl/q_gate_pipe_if.sv - input/output handshake bundle for the gate unit
interface q_gate_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_op;
    logic [TAG_W-1:0]        in_tag;
    logic signed [WIDTH-1:0] in_a_re;
    logic signed [WIDTH-1:0] in_a_im;
    logic signed [WIDTH-1:0] in_b_re;
    logic signed [WIDTH-1:0] in_b_im;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_a_re;
    logic signed [WIDTH-1:0] out_a_im;
    logic signed [WIDTH-1:0] out_b_re;
    logic signed [WIDTH-1:0] out_b_im;
    logic [TAG_W-1:0]        out_tag;
    logic                    out_sat;
    logic                    out_err;

    modport master (
        output in_valid, in_op, in_tag, in_a_re, in_a_im, in_b_re, in_b_im, out_ready,
        input  in_ready, out_valid, out_a_re, out_a_im, out_b_re, out_b_im,
               out_tag, out_sat, out_err
    );

    modport slave (
        input  in_valid, in_op, in_tag, in_a_re, in_a_im, in_b_re, in_b_im, out_ready,
        output in_ready, out_valid, out_a_re, out_a_im, out_b_re, out_b_im,
               out_tag, out_sat, out_err
    );
endinterface

// File: rtl/q_gate_pipe_scale_rs.sv
// rtl/q_gate_pipe_scale_rs.sv - per-component scale, round-half-up and saturate (S2/S3)
module q_scale_rs
    import q_gate_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int KW    = FRAC + 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH:0]   v_i,
    input  logic                    scale_i,
    input  logic signed [KW-1:0]    k_i,
    output logic signed [WIDTH-1:0] res_o,
    output logic                    sat_o
);
    localparam int PW = WIDTH + 1 + KW;

    localparam logic signed [PW:0] HALF = (PW+1)'(1) <<< (FRAC - 1);
    localparam logic signed [PW:0] MAXV = (PW+1)'(sat_neg(WIDTH));
    localparam logic signed [PW:0] MINV = -MAXV - (PW+1)'(1);

    logic signed [PW-1:0]    prod_d;
    logic signed [PW-1:0]    prod_q;
    logic signed [PW:0]      sum_w;
    logic signed [PW:0]      shr_w;
    logic signed [WIDTH-1:0] res_d;
    logic signed [WIDTH-1:0] res_q;
    logic                    sat_d;
    logic                    sat_q;

    // Unscaled ops shift up by FRAC so the shared rounder returns them unchanged
    always_comb begin
        prod_d = PW'(v_i) <<< FRAC;
        if (scale_i) begin
            prod_d = PW'(v_i) * PW'(k_i);
        end
    end

    // S2: full-precision product register
    always_ff @(posedge clk) begin
        if (en) begin
            prod_q <= prod_d;
        end
    end

    // Round half up (add half LSB, arithmetic shift) then clamp into WIDTH
    always_comb begin
        sum_w = (PW+1)'(prod_q) + HALF;
        shr_w = sum_w >>> FRAC;
        res_d = shr_w[WIDTH-1:0];
        sat_d = 1'b0;
        if (shr_w > MAXV) begin
            res_d = MAXV[WIDTH-1:0];
            sat_d = 1'b1;
        end else if (shr_w < MINV) begin
            res_d = MINV[WIDTH-1:0];
            sat_d = 1'b1;
        end
    end

    // S3: result register; sat flag cleared by reset so it never leaks stale state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (en) begin
            res_q <= res_d;
            sat_q <= sat_d;
        end
    end

    assign res_o = res_q;
    assign sat_o = sat_q;
endmodule

// File: rtl/q_gate_pipe.sv
// rtl/q_gate_pipe.sv - three-stage single-qubit gate unit with valid/ready flow control
module q_gate_pipe
    import q_gate_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int TAG_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    q_gate_pipe_if.slave  bus
);
    localparam int KW = FRAC + 2;
    localparam logic signed [KW-1:0] K = KW'(inv_sqrt2_const(FRAC));

    logic en;

    logic v1_q, v2_q, v3_q;
    logic err3_q;

    logic signed [WIDTH:0] ar, ai, br, bi;
    logic signed [WIDTH:0] s1_d [4];
    logic [3:0]            sc_d;
    logic                  err_d;

    logic signed [WIDTH:0] s1_q [4];
    logic [3:0]            sc_q;
    logic [TAG_W-1:0]      tag1_q, tag2_q, tag3_q;
    logic                  err1_q, err2_q;

    logic signed [WIDTH-1:0] res [4];
    logic [3:0]              sat;

    // One enable for the whole pipe: advance whenever the output slot is free or draining
    assign en           = ~v3_q | bus.out_ready;
    assign bus.in_ready = en;

    assign ar = {bus.in_a_re[WIDTH-1], bus.in_a_re};
    assign ai = {bus.in_a_im[WIDTH-1], bus.in_a_im};
    assign br = {bus.in_b_re[WIDTH-1], bus.in_b_re};
    assign bi = {bus.in_b_im[WIDTH-1], bus.in_b_im};

    // S1 operand permutation and add/sub; the extra bit holds sums and -(-2^(W-1))
    always_comb begin
        s1_d[0] = ar;
        s1_d[1] = ai;
        s1_d[2] = br;
        s1_d[3] = bi;
        sc_d    = 4'b0000;
        err_d   = 1'b0;
        case (op_e'(bus.in_op))
            OP_I: ;
            OP_X: begin
                s1_d[0] = br;
                s1_d[1] = bi;
                s1_d[2] = ar;
                s1_d[3] = ai;
            end
            OP_Z: begin
                s1_d[2] = -br;
                s1_d[3] = -bi;
            end
            OP_H: begin
                s1_d[0] = ar + br;
                s1_d[1] = ai + bi;
                s1_d[2] = ar - br;
                s1_d[3] = ai - bi;
                sc_d    = 4'b1111;
            end
            OP_S: begin
                s1_d[2] = -bi;
                s1_d[3] = br;
            end
            OP_T: begin
                s1_d[2] = br - bi;
                s1_d[3] = br + bi;
                sc_d    = 4'b1100;
            end
            OP_Y: begin
                s1_d[0] = bi;
                s1_d[1] = -br;
                s1_d[2] = -ai;
                s1_d[3] = ar;
            end
            OP_RSVD: err_d = 1'b1;
            default: ;
        endcase
    end

    // Stage-valid chain and output error flag; the only state that reset clears
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            err3_q <= 1'b0;
        end else if (en) begin
            v1_q   <= bus.in_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            err3_q <= err2_q;
        end
    end

    // S1 operand registers plus sideband capture
    always_ff @(posedge clk) begin
        if (en) begin
            s1_q   <= s1_d;
            sc_q   <= sc_d;
            tag1_q <= bus.in_tag;
            err1_q <= err_d;
        end
    end

    // Sideband travels alongside the S2/S3 data registers inside the scalers
    always_ff @(posedge clk) begin
        if (en) begin
            tag2_q <= tag1_q;
            err2_q <= err1_q;
            tag3_q <= tag2_q;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_scale
        q_scale_rs #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .KW    (KW)
        ) u_scale (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .v_i     (s1_q[g]),
            .scale_i (sc_q[g]),
            .k_i     (K),
            .res_o   (res[g]),
            .sat_o   (sat[g])
        );
    end

    assign bus.out_valid = v3_q;
    assign bus.out_a_re  = res[0];
    assign bus.out_a_im  = res[1];
    assign bus.out_b_re  = res[2];
    assign bus.out_b_im  = res[3];
    assign bus.out_tag   = tag3_q;
    // Bubbles carry stale data through the scalers, so flags are qualified by valid
    assign bus.out_sat   = v3_q & (|sat);
    assign bus.out_err   = v3_q & err3_q;
endmodule

// File: tb/tb_q_gate_pipe.sv
// tb/tb_q_gate_pipe.sv - scoreboard bench for q_gate_pipe with random and directed beats
module tb_q_gate_pipe;
    import q_gate_pkg::*;

    localparam int W     = 16;
    localparam int FR    = 12;
    localparam int TW    = 8;
    localparam int K_REF = 2896;
    localparam int VMAX  = 32767;
    localparam int VMIN  = -32768;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    q_gate_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    q_gate_pipe #(.WIDTH(W), .FRAC(FR), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int a_re, a_im, b_re, b_im;
        int tag;
        bit sat, err;
        int cyc;
        bit exact;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   n_drop = 0;
    bit   free_run = 1'b1;
    bit   rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // floor((x + 2^(FRAC-1)) / 2^FRAC) done with integer division
    function automatic int rdiv(input longint x);
        longint n;
        longint q;
        n = x + 2048;
        q = n / 4096;
        if ((n % 4096 != 0) && (n < 0)) q = q - 1;
        return int'(q);
    endfunction

    function automatic exp_t model(input beat_t b);
        exp_t e;
        int   a0, a1, b0, b1;
        int   v[4];
        bit   sc[4];
        int   r;
        a0 = b.a_re; a1 = b.a_im; b0 = b.b_re; b1 = b.b_im;
        v  = '{a0, a1, b0, b1};
        sc = '{0, 0, 0, 0};
        e.err = 1'b0;
        e.sat = 1'b0;
        case (b.op)
            OP_X: v = '{b0, b1, a0, a1};
            OP_Z: v = '{a0, a1, -b0, -b1};
            OP_H: begin v = '{a0 + b0, a1 + b1, a0 - b0, a1 - b1}; sc = '{1, 1, 1, 1}; end
            OP_S: v = '{a0, a1, -b1, b0};
            OP_T: begin v = '{a0, a1, b0 - b1, b0 + b1}; sc = '{0, 0, 1, 1}; end
            OP_Y: v = '{b1, -b0, -a1, a0};
            OP_RSVD: e.err = 1'b1;
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            r = sc[i] ? rdiv(longint'(v[i]) * K_REF) : v[i];
            if (r > VMAX) begin r = VMAX; e.sat = 1'b1; end
            else if (r < VMIN) begin r = VMIN; e.sat = 1'b1; end
            v[i] = r;
        end
        e.a_re = v[0]; e.a_im = v[1]; e.b_re = v[2]; e.b_im = v[3];
        e.tag  = int'(b.tag);
        e.cyc  = 0;
        e.exact = 1'b0;
        return e;
    endfunction

    function automatic beat_t mk(input op_e op, input int ar, input int ai,
                                 input int br, input int bi, input int tag);
        beat_t b;
        b.op   = op;
        b.a_re = W'(ar);
        b.a_im = W'(ai);
        b.b_re = W'(br);
        b.b_im = W'(bi);
        b.tag  = TW'(tag);
        return b;
    endfunction

    function automatic int rv();
        case ($urandom_range(0, 7))
            0: return VMAX;
            1: return VMIN;
            2: return 4096;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Present one beat, push its expectation at the handshake, release after the edge
    task automatic send(input beat_t b);
        exp_t e;
        bit   acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = b.op;
        bus.in_tag   = b.tag;
        bus.in_a_re  = b.a_re;
        bus.in_a_im  = b.a_im;
        bus.in_b_re  = b.b_re;
        bus.in_b_im  = b.b_im;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e = model(b);
                e.cyc = cyc;
                e.exact = free_run;
                sb.push_back(e);
                n_acc++;
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: compare every delivered beat against the head of the scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready_rule", bus.in_ready, (!bus.out_valid) || bus.out_ready);
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        n_out++;
                        chk("a_re", bus.out_a_re, e.a_re);
                        chk("a_im", bus.out_a_im, e.a_im);
                        chk("b_re", bus.out_b_re, e.b_re);
                        chk("b_im", bus.out_b_im, e.b_im);
                        chk("tag",  bus.out_tag,  e.tag);
                        chk("sat",  bus.out_sat,  e.sat);
                        chk("err",  bus.out_err,  e.err);
                        if (e.exact) chk("latency", cyc - e.cyc, 3);
                    end
                end
            end
        end
    end

    initial begin : stim
        int base;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_tag    = '0;
        bus.in_a_re   = '0;
        bus.in_a_im   = '0;
        bus.in_b_re   = '0;
        bus.in_b_im   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_sat",   bus.out_sat,   0);
        chk("reset_out_err",   bus.out_err,   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready",  bus.in_ready,  1);
        chk("post_reset_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // Directed vectors, free-running output so latency must be exactly 3
        send(mk(OP_H, 4096, 0, 0, 0, 1));
        send(mk(OP_H, 2896, 0, 2896, 0, 2));
        send(mk(OP_Y, 4096, 0, 0, 0, 3));
        send(mk(OP_S, 0, 0, 0, 4096, 4));
        send(mk(OP_RSVD, 123, -456, 789, -1000, 5));
        send(mk(OP_H, 32767, 0, 32767, 0, 6));
        send(mk(OP_Z, 0, 0, -32768, 0, 7));
        send(mk(OP_S, 5, 6, 100, -32768, 8));
        send(mk(OP_T, 1000, -2000, -32768, 32767, 9));
        send(mk(OP_X, -32768, 32767, 17, -17, 10));
        send(mk(OP_H, -32768, -32768, -32768, 32767, 11));
        idle(5);
        drain();

        // Eight back-to-back beats with out_ready dropped on relative cycles 4..8
        free_run = 1'b0;
        fork
            begin
                for (int t = 0; t < 8; t++)
                    send(mk(op_e'($urandom_range(0, 6)), rv(), rv(), rv(), rv(), t));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_in_ready", bus.in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Randomised traffic with random backpressure and input gaps
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                    send(mk(op_e'($urandom_range(0, 7)), rv(), rv(), rv(), rv(),
                            int'($urandom_range(0, 255))));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight: nothing stale may appear afterwards
        free_run = 1'b1;
        send(mk(OP_H, 4096, 0, 0, 0, 8'hA0));
        send(mk(OP_X, 1, 2, 3, 4, 8'hA1));
        send(mk(OP_Z, 5, 6, 7, 8, 8'hA2));
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_drop = sb.size();
        sb.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("reset_flush_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        send(mk(OP_T, 4096, 4096, 4096, -4096, 8'hB0));
        idle(10);
        drain();
        chk("beat_count", n_out, n_acc - n_drop);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
